// File: rtl/phase_pkg.sv
// Shared encodings for the four-phase instruction-cycle controller.
// States are one-hot; each phase index names the flop that carries that state.
package phase_pkg;

  localparam int PH_IDLE = 0;
  localparam int PH_P1   = 1;
  localparam int PH_P2   = 2;
  localparam int PH_P3   = 3;
  localparam int PH_P4   = 4;
  localparam int PH_ERR  = 5;

  localparam logic [5:0] ST_IDLE = 6'b000001;
  localparam logic [5:0] ST_P1   = 6'b000010;
  localparam logic [5:0] ST_P2   = 6'b000100;
  localparam logic [5:0] ST_P3   = 6'b001000;
  localparam logic [5:0] ST_P4   = 6'b010000;
  localparam logic [5:0] ST_ERR  = 6'b100000;

  localparam int DEFAULT_WAIT_MAX = 15;

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the processor core and the phase sequencer.
interface phase_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             step_mode;
  logic             halt_req;
  logic             mem_ready;
  logic             p1;
  logic             p2;
  logic             p3;
  logic             p4;
  logic             running;
  logic             halted;
  logic             bus_error;
  logic [CNT_W-1:0] retired;

  modport master (
    output start, step_mode, halt_req, mem_ready,
    input  p1, p2, p3, p4, running, halted, bus_error, retired
  );

  modport slave (
    input  start, step_mode, halt_req, mem_ready,
    output p1, p2, p3, p4, running, halted, bus_error, retired
  );
endinterface

// File: rtl/wait_timer.sv
// Counts cycles that fetch has been stretched waiting for instruction memory.
// expired is high once the count has reached WAIT_MAX.
module wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt == 8'(WAIT_MAX));

endmodule

// File: rtl/phase_sequencer.sv
// Four-phase instruction-cycle controller: one-hot phase FSM with fetch stretch,
// bus-error timeout, run/halt/single-step control and a retired-instruction counter.
module phase_sequencer
  import phase_pkg::*;
#(
  parameter int WAIT_MAX = DEFAULT_WAIT_MAX,
  parameter int CNT_W    = 16
) (
  input logic               clk,
  input logic               reset,
  phase_sequencer_if.slave  bus
);

  logic [5:0]       state;
  logic [5:0]       state_nxt;
  logic             halt_lat;
  logic             halted_q;
  logic [CNT_W-1:0] retired_q;
  logic             in_phase;
  logic             halt_now;
  logic             wait_expired;
  logic             wait_clr;
  logic             wait_en;

  assign in_phase = |state[PH_P4:PH_P1];
  // A halt_req arriving during P4 itself must still end the run at this P4 exit.
  assign halt_now = halt_lat | (bus.halt_req & state[PH_P4]);

  assign wait_clr = ~state[PH_P1] | bus.mem_ready | wait_expired;
  assign wait_en  = state[PH_P1] & ~bus.mem_ready;

  wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (wait_clr),
    .en      (wait_en),
    .expired (wait_expired)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_P1;
      ST_P1: begin
        if (bus.mem_ready)      state_nxt = ST_P2;
        else if (wait_expired)  state_nxt = ST_ERR;
      end
      ST_P2:   state_nxt = ST_P3;
      ST_P3:   state_nxt = ST_P4;
      ST_P4: begin
        if (halt_now || bus.step_mode) state_nxt = ST_IDLE;
        else                           state_nxt = ST_P1;
      end
      ST_ERR:  if (bus.start) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halt_lat <= 1'b0;
    end else if (state_nxt[PH_IDLE]) begin
      halt_lat <= 1'b0;
    end else if (in_phase && bus.halt_req) begin
      halt_lat <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted_q <= 1'b0;
    end else if (state[PH_IDLE] && bus.start) begin
      halted_q <= 1'b0;
    end else if (state[PH_P4] && halt_now) begin
      halted_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else if (state[PH_P4]) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  assign bus.p1        = state[PH_P1];
  assign bus.p2        = state[PH_P2];
  assign bus.p3        = state[PH_P3];
  assign bus.p4        = state[PH_P4];
  assign bus.running   = in_phase;
  assign bus.bus_error = state[PH_ERR];
  assign bus.halted    = halted_q;
  assign bus.retired   = retired_q;

endmodule
